// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: option bit indices, baud codes,
//               FSM state encoding and the baud divisor helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int BAUD_LSB = 0;
    localparam int BAUD_MSB = 1;
    localparam int PAR_EN   = 2;
    localparam int PAR_ODD  = 3;
    localparam int STOP2    = 4;

    localparam logic [1:0] BAUD_9600   = 2'd0;
    localparam logic [1:0] BAUD_19200  = 2'd1;
    localparam logic [1:0] BAUD_57600  = 2'd2;
    localparam logic [1:0] BAUD_115200 = 2'd3;

    localparam int DIV_W = 32;

    localparam int unsigned BAUD_RATES [4] = '{32'd9600, 32'd19200, 32'd57600, 32'd115200};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Truncating divide; only ever evaluated at elaboration time.
    function automatic logic [DIV_W-1:0] baud_divisor(input int unsigned clk_freq,
                                                      input logic [1:0]  sel);
        return DIV_W'(clk_freq / BAUD_RATES[sel]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Byte/handshake interface between the host logic and uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic [7:0]           usr_options;
    logic                 tx_start;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data, usr_options, tx_start,
        input  tx_ready, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, usr_options, tx_start,
        output tx_ready, tx_busy, tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period timer. o_tick pulses every i_div cycles; o_tick_early
//               pulses one cycle before it. i_clear restarts the period at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clear,
    input  wire logic [DIV_W-1:0] i_div,
    output logic                  o_tick,
    output logic                  o_tick_early
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick       = (r_cnt == i_div - DIV_W'(1));
    assign o_tick_early = (r_cnt == i_div - DIV_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART serialiser (start, LSB-first data, optional parity,
//               1 or 2 stop bits). Define UART_TX_FIFO_EN for a 4-entry
//               byte FIFO in front of the FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int DATA_BITS = 8
) (
    input  wire logic  sys_clk,
    input  wire logic  reset,
    uart_tx_if.slave   host,
    output logic       serial_out
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    localparam logic [DIV_W-1:0] DIV_TABLE [4] = '{
        baud_divisor(CLK_FREQ, BAUD_9600),
        baud_divisor(CLK_FREQ, BAUD_19200),
        baud_divisor(CLK_FREQ, BAUD_57600),
        baud_divisor(CLK_FREQ, BAUD_115200)
    };

    uart_state_t          r_state;
    logic                 r_serial;
    logic                 r_busy;
    logic                 r_done;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_par_en;
    logic                 r_stop2;
    logic                 r_parity;
    logic [DIV_W-1:0]     r_div;

    logic                 w_load;
    logic [DATA_BITS-1:0] w_load_data;
    logic [7:0]           w_load_opts;
    logic                 w_tick;
    logic                 w_tick_early;
    logic                 w_idle;
    logic                 w_stop_end;
    logic                 w_unused_opts;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_load_opts   = host.usr_options;
    assign w_unused_opts = ^host.usr_options[7:5];
    assign serial_out    = r_serial;
    assign host.tx_done  = r_done;

    // The last stop period hands over one cycle early: the line is already
    // high, so a new frame accepted in the tx_done cycle starts gap-free.
    assign w_stop_end = w_tick_early && (!r_stop2 || r_stop_cnt);

    uart_baud_gen u_baud_gen (
        .clk          (sys_clk),
        .rst_n        (reset),
        .i_clear      (w_idle),
        .i_div        (r_div),
        .o_tick       (w_tick),
        .o_tick_early (w_tick_early)
    );

`ifdef UART_TX_FIFO_EN
    localparam int FIFO_DEPTH = 4;

    logic [DATA_BITS-1:0] r_fifo [FIFO_DEPTH];
    logic [1:0]           r_wr_ptr;
    logic [1:0]           r_rd_ptr;
    logic [2:0]           r_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;

    assign w_full        = (r_count == 3'(FIFO_DEPTH));
    assign w_empty       = (r_count == 3'd0);
    assign w_push        = host.tx_start && !w_full;
    // Pop only from the registered count, so a push into an empty FIFO
    // is seen by the FSM one cycle later.
    assign w_load        = w_idle && !w_empty;
    assign w_load_data   = r_fifo[r_rd_ptr];
    assign host.tx_ready = !w_full;
    assign host.tx_busy  = r_busy || !w_empty;

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= host.tx_data;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_load};
        end
    end
`else
    assign w_load        = host.tx_start && !r_busy;
    assign w_load_data   = host.tx_data;
    assign host.tx_ready = !r_busy;
    assign host.tx_busy  = r_busy;
`endif

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_serial   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_en   <= 1'b0;
            r_stop2    <= 1'b0;
            r_parity   <= 1'b0;
            r_div      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state    <= ST_START;
                        r_serial   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_shift    <= w_load_data;
                        r_parity   <= (^w_load_data) ^ w_load_opts[PAR_ODD];
                        r_par_en   <= w_load_opts[PAR_EN];
                        r_stop2    <= w_load_opts[STOP2];
                        r_div      <= DIV_TABLE[w_load_opts[BAUD_MSB:BAUD_LSB]];
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state  <= ST_DATA;
                        r_serial <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            if (r_par_en) begin
                                r_state  <= ST_PARITY;
                                r_serial <= r_parity;
                            end else begin
                                r_state  <= ST_STOP;
                                r_serial <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_shift   <= r_shift >> 1;
                            r_serial  <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state  <= ST_STOP;
                        r_serial <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_stop_end) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_tick) begin
                        r_stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx; the line is recorded per
//               cycle and frames are compared bit period by bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CLK_FREQ = 50000000;
    localparam int MAXC     = 100000;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic serial_out;

    uart_tx_if #(.DATA_BITS(8)) bus();

    uart_tx #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(8)) dut (
        .sys_clk    (clk),
        .reset      (rst_n),
        .host       (bus),
        .serial_out (serial_out)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic line_h [MAXC];
    logic done_h [MAXC];
    logic busy_h [MAXC];
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            line_h[cyc] = serial_out;
            done_h[cyc] = bus.tx_done;
            busy_h[cyc] = bus.tx_busy;
        end
    end

    function automatic int div_of(input logic [7:0] o);
        case (o[1:0])
            2'd0:    return CLK_FREQ / 9600;
            2'd1:    return CLK_FREQ / 19200;
            2'd2:    return CLK_FREQ / 57600;
            default: return CLK_FREQ / 115200;
        endcase
    endfunction

    function automatic int nbits_of(input logic [7:0] o);
        return 10 + int'(o[2]) + int'(o[4]);
    endfunction

    function automatic logic bit_of(input logic [7:0] d, input logic [7:0] o, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (o[2] && b == 9) return (($countones(d) % 2) == 1) ^ o[3];
        return 1'b1;
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic present(input logic [7:0] d, input logic [7:0] o, output int k);
        bus.tx_data     = d;
        bus.usr_options = o;
        bus.tx_start    = 1'b1;
        k = cyc;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    // Frame whose start bit occupies cycle s onward.
    task automatic check_frame(input int s, input logic [7:0] d, input logic [7:0] o, input string tag);
        int   div;
        int   n;
        int   early;
        logic obs;
        logic expb;
        div   = div_of(o);
        n     = nbits_of(o);
        early = 0;
        for (int b = 0; b < n; b++) begin
            obs = line_h[s + b*div];
            for (int i = 1; i < div; i++)
                if (line_h[s + b*div + i] !== obs) obs = 1'bx;
            expb = bit_of(d, o, b);
            checks++;
            if (obs !== expb) begin
                failures++;
                $display("FAIL %s bit%0d: line=%b expected=%b", tag, b, obs, expb);
            end
        end
        checks++;
        if (line_h[s-1] !== 1'b1) begin
            failures++;
            $display("FAIL %s pre-start line: got=%b expected=1", tag, line_h[s-1]);
        end
        checks++;
        if (done_h[s + n*div - 1] !== 1'b1) begin
            failures++;
            $display("FAIL %s tx_done at last cycle: got=%b expected=1", tag, done_h[s + n*div - 1]);
        end
        for (int c = s; c < s + n*div - 1; c++)
            if (done_h[c] === 1'b1) early++;
        checks++;
        if (early !== 0) begin
            failures++;
            $display("FAIL %s early tx_done pulses: got=%0d expected=0", tag, early);
        end
        checks++;
        if (busy_h[s] !== 1'b1) begin
            failures++;
            $display("FAIL %s tx_busy in frame: got=%b expected=1", tag, busy_h[s]);
        end
    endtask

    task automatic test_reset();
        bus.tx_data     = 8'h00;
        bus.usr_options = 8'h03;
        bus.tx_start    = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (serial_out !== 1'b1) begin failures++; $display("FAIL reset serial_out: got=%b expected=1", serial_out); end
        checks++;
        if (bus.tx_busy !== 1'b0) begin failures++; $display("FAIL reset tx_busy: got=%b expected=0", bus.tx_busy); end
        checks++;
        if (bus.tx_done !== 1'b0) begin failures++; $display("FAIL reset tx_done: got=%b expected=0", bus.tx_done); end
        checks++;
        if (bus.tx_ready !== 1'b1) begin failures++; $display("FAIL reset tx_ready: got=%b expected=1", bus.tx_ready); end
    endtask

    task automatic test_basic();
        int k;
        present(8'h55, 8'h03, k);
        wait_cyc(k + LAT + 4340 + 3);
        check_frame(k + LAT, 8'h55, 8'h03, "basic55");
    endtask

    task automatic test_parity();
        int k;
        present(8'hA5, 8'h07, k);
        wait_cyc(k + LAT + 11*434 + 3);
        check_frame(k + LAT, 8'hA5, 8'h07, "even_par");
        present(8'hA5, 8'h0F, k);
        wait_cyc(k + LAT + 11*434 + 3);
        check_frame(k + LAT, 8'hA5, 8'h0F, "odd_par");
    endtask

`ifndef UART_TX_FIFO_EN
    task automatic test_back_to_back();
        int k;
        int k2;
        int n1;
        int run;
        n1 = nbits_of(8'h13) * div_of(8'h13);
        present(8'h00, 8'h13, k);
        wait_cyc(k + n1);
        checks++;
        if (bus.tx_done !== 1'b1) begin failures++; $display("FAIL b2b done cycle: got=%b expected=1", bus.tx_done); end
        present(8'hFF, 8'h13, k2);
        wait_cyc(k2 + 1 + n1 + 3);
        check_frame(k + 1, 8'h00, 8'h13, "b2b_first");
        check_frame(k2 + 1, 8'hFF, 8'h13, "b2b_second");
        run = 0;
        for (int c = k2; c > k && line_h[c] === 1'b1; c--) run++;
        checks++;
        if (run !== 2*div_of(8'h13)) begin
            failures++;
            $display("FAIL b2b gap: high_cycles=%0d expected=%0d", run, 2*div_of(8'h13));
        end
    endtask

    task automatic test_latch_ignore();
        int k;
        int bad;
        present(8'h3C, 8'h03, k);
        wait_cyc(k + 1000);
        bus.tx_data     = 8'hFF;
        bus.usr_options = 8'h00;
        bus.tx_start    = 1'b1;
        @(negedge clk);
        bus.tx_start    = 1'b0;
        bus.usr_options = 8'h03;
        wait_cyc(k + 1 + 4340 + 30);
        check_frame(k + 1, 8'h3C, 8'h03, "latched");
        bad = 0;
        for (int c = k + 4341; c < k + 4370; c++)
            if (done_h[c] !== 1'b0 || busy_h[c] !== 1'b0) bad++;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL ignored start: busy_or_done_cycles=%0d expected=0", bad); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int k;
        int bad;
        present(8'h96, 8'h03, k);
        wait_cyc(k + 2000);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (serial_out !== 1'b1) begin failures++; $display("FAIL midreset serial_out: got=%b expected=1", serial_out); end
        checks++;
        if (bus.tx_busy !== 1'b0) begin failures++; $display("FAIL midreset tx_busy: got=%b expected=0", bus.tx_busy); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(k + 4400);
        bad = 0;
        for (int c = k + 2001; c < k + 4400; c++)
            if (done_h[c] !== 1'b0 || line_h[c] !== 1'b1) bad++;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL midreset abandoned frame: bad_cycles=%0d expected=0", bad); end
        present(8'h69, 8'h03, k);
        wait_cyc(k + LAT + 4340 + 3);
        check_frame(k + LAT, 8'h69, 8'h03, "after_reset");
    endtask

    task automatic test_random();
        int          k;
        logic [7:0]  d;
        logic [7:0]  o;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            o = 8'($urandom);
            o[1:0] = (i == 0) ? 2'd2 : 2'd3;
            present(d, o, k);
            wait_cyc(k + LAT + nbits_of(o)*div_of(o) + 3);
            check_frame(k + LAT, d, o, $sformatf("rand%0d_d%02h_o%02h", i, d, o));
        end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo();
        int         k;
        int         s0;
        int         n;
        int         dones;
        logic [7:0] q [5];
        logic [7:0] sent [5];
        n = 4340;
        present(8'h11, 8'h03, k);
        s0 = k + 2;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) q[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.tx_ready !== (i < 4)) begin
                failures++;
                $display("FAIL fifo ready before push%0d: got=%b expected=%b", i, bus.tx_ready, (i < 4));
            end
            bus.tx_data  = q[i];
            bus.tx_start = 1'b1;
            @(negedge clk);
        end
        bus.tx_start = 1'b0;
        checks++;
        if (bus.tx_ready !== 1'b0) begin failures++; $display("FAIL fifo ready when full: got=%b expected=0", bus.tx_ready); end
        sent[0] = 8'h11;
        for (int i = 1; i < 5; i++) sent[i] = q[i-1];
        wait_cyc(s0 + 5*n + 5);
        for (int j = 0; j < 5; j++)
            check_frame(s0 + j*n, sent[j], 8'h03, $sformatf("fifo%0d", j));
        dones = 0;
        for (int c = s0; c < s0 + 5*n + 5; c++)
            if (done_h[c] === 1'b1) dones++;
        checks++;
        if (dones !== 5) begin failures++; $display("FAIL fifo done count: got=%0d expected=5", dones); end
        checks++;
        if (bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL fifo drained: busy=%b ready=%b expected busy=0 ready=1", bus.tx_busy, bus.tx_ready);
        end
    endtask
`endif

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
`ifndef UART_TX_FIFO_EN
        test_back_to_back();
        test_latch_ignore();
`endif
        test_reset_mid_frame();
        test_random();
`ifdef UART_TX_FIFO_EN
        test_fifo();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
